arbiter_n_to_1_request_wrr: RTL and testbench

Weighted round-robin successor to the cache-side N-to-1 memory request arbiter. It funnels `NUM_MEMORY_REQUESTOR` engine request streams into one cache request stream. Each channel gets an input FIFO and a programmable burst weight, and arbitration is either weighted round-robin or fixed priority. Every output packet carries the winning channel index, and per-channel overflow is flagged. It sits between the engine request ports and the cache/AXI request FIFO, replacing the fixed 2-channel-style round-robin arbiter.

---
 rtl/arbiter_n_to_1_request_wrr_pkg.sv | 45 ++++
 rtl/arbiter_n_to_1_request_wrr_select.sv | 32 +++
 rtl/arbiter_n_to_1_request_wrr.sv | 179 +++++++++++++++++
 tb/tb_arbiter_n_to_1_request_wrr.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_n_to_1_request_wrr_pkg.sv
// arbiter_n_to_1_request_wrr_pkg: shared types for the weighted round-robin request arbiter.
// Provides arbiter mode codes, FSM state enum, request/tagged packet structs,
// FIFO state structs and the internal-to-output FIFO state mapping helper.
package arbiter_n_to_1_request_wrr_pkg;
    localparam logic ARBITER_MODE_WRR   = 1'b0;
    localparam logic ARBITER_MODE_FIXED = 1'b1;

    typedef enum logic {IDLE, OWN} ArbiterWRRState;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] data;
    } MemoryPacketPayload;

    typedef struct packed {
        logic               valid;
        MemoryPacketPayload payload;
    } MemoryPacketRequest;

    // Output FIFO word: payload plus the channel it came from (wide enough for 16 channels).
    typedef struct packed {
        logic [3:0]         id;
        MemoryPacketPayload payload;
    } MemoryPacketRequestTagged;

    typedef struct packed {
        logic rd_en;
    } FIFOStateSignalsInput;

    typedef struct packed {
        logic empty;
        logic prog_full;
    } FIFOStateSignalsOutput;

    typedef struct packed {
        logic empty;
        logic prog_full;
        logic wr_rst_busy;
        logic rd_rst_busy;
    } FIFOStateSignalsOutputInternal;

    function automatic FIFOStateSignalsOutput map_internal_fifo_signals_to_output(input FIFOStateSignalsOutputInternal s);
        return '{empty: s.empty, prog_full: s.prog_full};
    endfunction
endpackage

// File: rtl/arbiter_n_to_1_request_wrr_select.sv
// arbiter_wrr_select: combinational next-channel picker for the request arbiter.
// Ports: mask (channels with pending data), last (previously served channel),
// mode (WRR searches from last+1, FIXED from index 0), grant (one-hot choice, zero if mask empty).
module arbiter_wrr_select
    import arbiter_n_to_1_request_wrr_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    mask,
    input  logic [ID_W-1:0] last,
    input  logic            mode,
    output logic [N-1:0]    grant
);
    int   start;
    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        start = (mode == ARBITER_MODE_FIXED) ? 0 : (int'(last) + 1) % N;
        for (int i = 0; i < N; i++) begin
            idx = (start + i) % N;
            if (!found && mask[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/arbiter_n_to_1_request_wrr.sv
// arbiter_n_to_1_request_wrr: N-to-1 memory request arbiter with per-channel input FIFOs and weights.
// Ports: ap_clk/areset (sync, active high); request_in[N] valid-qualified requests;
// weight_in/weight_load burst weights; fifo_request_signals_in.rd_en pops the output FIFO;
// fifo_request_signals_out output FIFO state; arbiter_grant_out per-channel ready;
// request_out/request_out_id arbitrated packet and its source; overflow_error sticky per channel;
// fifo_setup_signal high while the FIFOs are coming out of reset.
module arbiter_n_to_1_request_wrr
    import arbiter_n_to_1_request_wrr_pkg::*;
#(
    parameter int   NUM_MEMORY_REQUESTOR = 4,
    parameter logic ARBITER_MODE         = ARBITER_MODE_WRR,
    parameter int   WEIGHT_WIDTH         = 4,
    parameter int   FIFO_IN_DEPTH        = 16,
    parameter int   FIFO_IN_PROG_THRESH  = 12,
    parameter int   FIFO_OUT_DEPTH       = 32,
    parameter int   FIFO_OUT_PROG_THRESH = FIFO_OUT_DEPTH / 2,
    localparam int  N    = NUM_MEMORY_REQUESTOR,
    localparam int  ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                      ap_clk,
    input  logic                      areset,
    input  MemoryPacketRequest        request_in [N],
    input  logic [WEIGHT_WIDTH*N-1:0] weight_in,
    input  logic                      weight_load,
    input  FIFOStateSignalsInput      fifo_request_signals_in,
    output FIFOStateSignalsOutput     fifo_request_signals_out,
    output logic [N-1:0]              arbiter_grant_out,
    output MemoryPacketRequest        request_out,
    output logic [ID_W-1:0]           request_out_id,
    output logic [N-1:0]              overflow_error,
    output logic                      fifo_setup_signal
);
    localparam int IA = $clog2(FIFO_IN_DEPTH);
    localparam int OA = $clog2(FIFO_OUT_DEPTH);
    localparam logic [IA:0] IN_FULL  = (IA+1)'(FIFO_IN_DEPTH);
    localparam logic [IA:0] IN_PF    = (IA+1)'(FIFO_IN_PROG_THRESH);
    localparam logic [OA:0] OUT_FULL = (OA+1)'(FIFO_OUT_DEPTH);
    localparam logic [OA:0] OUT_PF   = (OA+1)'(FIFO_OUT_PROG_THRESH);

    logic                     areset_r;
    MemoryPacketRequest       in_reg [N];
    MemoryPacketPayload       in_mem [N][FIFO_IN_DEPTH];
    logic [IA-1:0]            in_wp [N];
    logic [IA-1:0]            in_rp [N];
    logic [IA:0]              in_cnt [N];
    logic [N-1:0]             in_push, in_avail, in_prog_full, pop, sel;
    logic [WEIGHT_WIDTH-1:0]  weight [N];
    logic [WEIGHT_WIDTH-1:0]  burst_cnt, cnt_n, eff_w;
    ArbiterWRRState           state, state_n;
    logic [ID_W-1:0]          cur, cur_n, last, last_n, sel_idx, pop_idx, sel_from;
    logic                     keep, pop_any, pop_allow;
    logic                     pop_valid, owr_valid, dout_valid;
    MemoryPacketRequestTagged pop_data, owr_data, dout;
    MemoryPacketRequestTagged out_mem [FIFO_OUT_DEPTH];
    logic [OA-1:0]            out_wp, out_rp;
    logic [OA:0]              out_cnt;
    logic                     out_push, out_rd, out_empty, out_prog_full;
    logic [1:0]               setup_cnt;

    // Single registered copy of reset drives every stage.
    always_ff @(posedge ap_clk) areset_r <= areset;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            in_push[i]      = in_reg[i].valid & (in_cnt[i] != IN_FULL);
            in_avail[i]     = in_cnt[i] != '0;
            in_prog_full[i] = in_cnt[i] >= IN_PF;
        end
    end

    always_ff @(posedge ap_clk) begin
        for (int i = 0; i < N; i++) begin
            if (in_push[i]) in_mem[i][in_wp[i]] <= in_reg[i].payload;
        end
    end

    always_ff @(posedge ap_clk) begin
        for (int i = 0; i < N; i++) begin
            in_reg[i] <= areset_r ? '0 : request_in[i];
            if (areset_r) begin
                in_wp[i]          <= '0;
                in_rp[i]          <= '0;
                in_cnt[i]         <= '0;
                overflow_error[i] <= 1'b0;
                weight[i]         <= WEIGHT_WIDTH'(1);
            end else begin
                in_wp[i]          <= in_wp[i] + IA'(in_push[i]);
                in_rp[i]          <= in_rp[i] + IA'(pop[i]);
                in_cnt[i]         <= in_cnt[i] + (IA+1)'(in_push[i]) - (IA+1)'(pop[i]);
                overflow_error[i] <= overflow_error[i] | (in_reg[i].valid & ~in_push[i]);
                if (weight_load) weight[i] <= weight_in[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end
        end
    end

    // While owning, the search starts after cur so the owner rotates to the back.
    assign sel_from = (state == OWN) ? cur : last;

    arbiter_wrr_select #(.N(N), .ID_W(ID_W)) u_select (
        .mask  (in_avail),
        .last  (sel_from),
        .mode  (ARBITER_MODE),
        .grant (sel)
    );

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < N; i++) if (sel[i]) sel_idx = ID_W'(i);
    end

    always_comb begin
        eff_w     = (weight[cur] == '0) ? WEIGHT_WIDTH'(1) : weight[cur];
        pop_allow = ~out_prog_full;
        keep      = (ARBITER_MODE == ARBITER_MODE_WRR) && (state == OWN) && in_avail[cur] && (burst_cnt < eff_w);
        pop_any   = pop_allow & (keep | (|in_avail));
        pop_idx   = keep ? cur : sel_idx;
        pop       = pop_any ? (N'(1) << pop_idx) : '0;
        state_n   = state;
        cur_n     = cur;
        last_n    = last;
        cnt_n     = burst_cnt;
        if (pop_allow) begin
            last_n  = (state == OWN && !keep) ? cur : last;
            state_n = pop_any ? OWN : IDLE;
            cur_n   = pop_any ? pop_idx : cur;
            cnt_n   = keep ? burst_cnt + 1'b1 : WEIGHT_WIDTH'(pop_any);
        end
    end

    always_ff @(posedge ap_clk) begin
        pop_data <= '{id: 4'(pop_idx), payload: in_mem[pop_idx][in_rp[pop_idx]]};
        owr_data <= pop_data;
        dout     <= out_mem[out_rp];
        if (out_push) out_mem[out_wp] <= owr_data;
    end

    assign out_empty     = out_cnt == '0;
    assign out_prog_full = out_cnt >= OUT_PF;
    assign out_push      = owr_valid & (out_cnt != OUT_FULL);
    assign out_rd        = fifo_request_signals_in.rd_en & ~out_empty;
    assign fifo_setup_signal = setup_cnt != 2'd0;

    always_ff @(posedge ap_clk) begin
        if (areset_r) begin
            state                    <= IDLE;
            cur                      <= '0;
            last                     <= ID_W'(N - 1);
            burst_cnt                <= '0;
            pop_valid                <= 1'b0;
            owr_valid                <= 1'b0;
            dout_valid               <= 1'b0;
            out_wp                   <= '0;
            out_rp                   <= '0;
            out_cnt                  <= '0;
            request_out              <= '0;
            request_out_id           <= '0;
            arbiter_grant_out        <= '0;
            fifo_request_signals_out <= 2'b10;
            setup_cnt                <= 2'd3;
        end else begin
            state                    <= state_n;
            cur                      <= cur_n;
            last                     <= last_n;
            burst_cnt                <= cnt_n;
            pop_valid                <= pop_any;
            owr_valid                <= pop_valid;
            dout_valid               <= out_rd;
            out_wp                   <= out_wp + OA'(out_push);
            out_rp                   <= out_rp + OA'(out_rd);
            out_cnt                  <= out_cnt + (OA+1)'(out_push) - (OA+1)'(out_rd);
            request_out              <= '{valid: dout_valid, payload: dout.payload};
            request_out_id           <= dout.id[ID_W-1:0];
            arbiter_grant_out        <= ~in_prog_full & {N{~out_prog_full}};
            fifo_request_signals_out <= map_internal_fifo_signals_to_output('{empty: out_empty, prog_full: out_prog_full,
                                            wr_rst_busy: fifo_setup_signal, rd_rst_busy: fifo_setup_signal});
            setup_cnt                <= (setup_cnt != 2'd0) ? setup_cnt - 2'd1 : 2'd0;
        end
    end
endmodule

// File: tb/tb_arbiter_n_to_1_request_wrr.sv
// tb_arbiter_n_to_1_request_wrr: directed self-checking bench for the WRR and FIXED arbiter variants.
module tb_arbiter_n_to_1_request_wrr;
    import arbiter_n_to_1_request_wrr_pkg::*;

    logic                  ap_clk = 1'b0;
    logic                  areset = 1'b1;
    MemoryPacketRequest    request_in [4];
    logic [15:0]           weight_in = '0;
    logic                  weight_load = 1'b0;
    FIFOStateSignalsInput  fin;
    FIFOStateSignalsOutput fout, fx_fout;
    logic [3:0]            grant, fx_grant, ovf, fx_ovf;
    MemoryPacketRequest    req_out, fx_out;
    logic [1:0]            req_id, fx_id;
    logic                  setup, fx_setup;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int q_id[$];
    int q_cyc[$];
    logic [31:0] q_addr[$];
    int fq_id[$];
    logic [31:0] fq_addr[$];
    int pat[7] = '{0, 0, 0, 1, 2, 2, 3};
    int seq[4];

    always #5 ap_clk = ~ap_clk;

    arbiter_n_to_1_request_wrr #(.ARBITER_MODE(ARBITER_MODE_WRR)) dut (
        .ap_clk(ap_clk), .areset(areset), .request_in(request_in), .weight_in(weight_in),
        .weight_load(weight_load), .fifo_request_signals_in(fin), .fifo_request_signals_out(fout),
        .arbiter_grant_out(grant), .request_out(req_out), .request_out_id(req_id),
        .overflow_error(ovf), .fifo_setup_signal(setup));

    arbiter_n_to_1_request_wrr #(.ARBITER_MODE(ARBITER_MODE_FIXED)) dut_fx (
        .ap_clk(ap_clk), .areset(areset), .request_in(request_in), .weight_in(weight_in),
        .weight_load(weight_load), .fifo_request_signals_in(fin), .fifo_request_signals_out(fx_fout),
        .arbiter_grant_out(fx_grant), .request_out(fx_out), .request_out_id(fx_id),
        .overflow_error(fx_ovf), .fifo_setup_signal(fx_setup));

    always @(negedge ap_clk) begin
        cyc++;
        if (req_out.valid) begin
            q_id.push_back(int'(req_id));
            q_addr.push_back(req_out.payload.address);
            q_cyc.push_back(cyc);
        end
        if (fx_out.valid) begin
            fq_id.push_back(int'(fx_id));
            fq_addr.push_back(fx_out.payload.address);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 4; i++) request_in[i] = '0;
    endtask

    task automatic drive(input int ch, input logic v, input logic [31:0] addr);
        request_in[ch].valid           = v;
        request_in[ch].payload.address = addr;
        request_in[ch].payload.data    = ~addr;
    endtask

    task automatic do_reset();
        @(negedge ap_clk);
        areset = 1'b1;
        idle_inputs();
        repeat (3) @(negedge ap_clk);
        areset = 1'b0;
        for (int k = 0; k < 20 && setup; k++) @(negedge ap_clk);
        check("setup_drop", setup, 1'b0);
        q_id.delete(); q_addr.delete(); q_cyc.delete(); fq_id.delete(); fq_addr.delete();
    endtask

    task automatic feed_all(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge ap_clk);
            for (int i = 0; i < 4; i++) begin
                drive(i, grant[i], 32'(i * 256 + seq[i]));
                if (grant[i]) seq[i]++;
            end
        end
        @(negedge ap_clk);
        idle_inputs();
    endtask

    initial begin
        fin.rd_en = 1'b1;
        idle_inputs();
        repeat (4) @(negedge ap_clk);
        check("rst_valid", req_out.valid, 1'b0);
        check("rst_id", req_id, 2'd0);
        check("rst_fifo", fout, 2'b10);
        check("rst_setup", setup, 1'b1);
        check("rst_grant", grant, 4'h0);
        check("rst_ovf", ovf, 4'h0);
        areset = 1'b0;
        for (int k = 0; k < 20 && setup; k++) @(negedge ap_clk);
        check("setup_drop", setup, 1'b0);
        @(negedge ap_clk);
        check("grant_up", grant, 4'hF);

        // single channel latency and ordering
        q_id.delete(); q_addr.delete(); q_cyc.delete(); fq_id.delete(); fq_addr.delete();
        for (int k = 0; k < 12; k++) begin
            @(negedge ap_clk);
            if (k == 6) check("lat_not_yet", req_out.valid, 1'b0);
            if (k == 7) begin
                check("lat_valid", req_out.valid, 1'b1);
                check("lat_id", req_id, 2'd2);
                check("lat_addr", req_out.payload.address, 32'h200);
            end
            if (k < 5) drive(2, 1'b1, 32'(32'h200 + k)); else idle_inputs();
        end
        repeat (5) @(negedge ap_clk);
        check("single_len", q_id.size(), 5);
        if (q_id.size() == 5)
            for (int k = 0; k < 5; k++) begin
                check("single_id", q_id[k], 2);
                check("single_addr", q_addr[k], 32'(32'h200 + k));
            end

        // WRR fairness with weights {3,1,2,1}
        do_reset();
        @(negedge ap_clk);
        weight_in = {4'd1, 4'd2, 4'd1, 4'd3};
        weight_load = 1'b1;
        @(negedge ap_clk);
        weight_load = 1'b0;
        for (int i = 0; i < 4; i++) seq[i] = 0;
        feed_all(40);
        repeat (10) @(negedge ap_clk);
        check("wrr_len", q_id.size() >= 21, 1'b1);
        if (q_id.size() >= 21) begin
            for (int j = 0; j < 21; j++) check("wrr_id", q_id[j], pat[j % 7]);
            check("wrr_nogap", q_cyc[20] - q_cyc[0], 20);
            check("wrr_ch2_second", q_addr[5], 32'h201);
        end

        // weight 0 behaves as 1
        do_reset();
        @(negedge ap_clk);
        weight_in = {4'd1, 4'd1, 4'd0, 4'd1};
        weight_load = 1'b1;
        @(negedge ap_clk);
        weight_load = 1'b0;
        for (int i = 0; i < 4; i++) seq[i] = 0;
        feed_all(20);
        repeat (10) @(negedge ap_clk);
        check("w0_len", q_id.size() >= 8, 1'b1);
        if (q_id.size() >= 8)
            for (int j = 0; j < 8; j++) check("w0_id", q_id[j], j % 4);

        // FIXED priority: channel 0 drains before channel 3
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge ap_clk);
            drive(0, 1'b1, 32'(k));
            drive(3, 1'b1, 32'(32'h300 + k));
        end
        @(negedge ap_clk);
        idle_inputs();
        repeat (20) @(negedge ap_clk);
        check("fx_len", fq_id.size(), 8);
        if (fq_id.size() == 8) begin
            for (int j = 0; j < 8; j++) check("fx_id", fq_id[j], (j < 4) ? 0 : 3);
            check("fx_addr_first3", fq_addr[4], 32'h300);
        end

        // backpressure honouring grant, then ignoring it
        do_reset();
        fin.rd_en = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge ap_clk);
            drive(0, grant[0], 32'(k));
        end
        @(negedge ap_clk);
        idle_inputs();
        repeat (10) @(negedge ap_clk);
        check("bp_grant_low", grant[0], 1'b0);
        check("bp_no_ovf", ovf, 4'h0);
        check("bp_fifo_pf", fout, 2'b01);
        check("bp_no_out", q_id.size(), 0);
        for (int k = 0; k < 20; k++) begin
            @(negedge ap_clk);
            drive(0, 1'b1, 32'(32'h1000 + k));
        end
        @(negedge ap_clk);
        idle_inputs();
        repeat (3) @(negedge ap_clk);
        check("bp_ovf_set", ovf, 4'h1);
        repeat (10) @(negedge ap_clk);
        check("bp_ovf_sticky", ovf, 4'h1);

        // reset while packets are queued
        @(negedge ap_clk);
        q_id.delete();
        areset = 1'b1;
        fin.rd_en = 1'b1;
        @(negedge ap_clk);
        areset = 1'b0;
        @(negedge ap_clk);
        check("mid_valid", req_out.valid, 1'b0);
        check("mid_fifo", fout, 2'b10);
        check("mid_ovf", ovf, 4'h0);
        check("mid_setup", setup, 1'b1);
        repeat (20) @(negedge ap_clk);
        check("mid_no_stale", q_id.size(), 0);
        drive(1, 1'b1, 32'h155);
        @(negedge ap_clk);
        idle_inputs();
        repeat (10) @(negedge ap_clk);
        check("post_len", q_id.size(), 1);
        if (q_id.size() == 1) check("post_id", q_id[0], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
